// File: rtl/cp0_pkg.sv
// Coprocessor-0 shared definitions: register indices, exception codes and
// the bit layout of SR and Cause.
package cp0_pkg;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_SR       = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;

    typedef enum logic [4:0] {
        EXC_INT     = 5'd0,
        EXC_ADEL    = 5'd4,
        EXC_ADES    = 5'd5,
        EXC_SYSCALL = 5'd8,
        EXC_RI      = 5'd10,
        EXC_OV      = 5'd12
    } exc_code_e;

    localparam int SR_IE        = 0;
    localparam int SR_EXL       = 1;
    localparam int SR_IM_LO     = 10;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_TI     = 30;
    localparam int CAUSE_BD     = 31;

    typedef struct packed {
        logic [5:0] im;
        logic       exl;
        logic       ie;
    } sr_t;

    typedef struct packed {
        logic       bd;
        logic [5:0] ip;
        logic [4:0] exc_code;
    } cause_t;

    function automatic logic [31:0] pack_sr(input sr_t sr);
        logic [31:0] w;
        w = '0;
        w[SR_IM_LO +: 6] = sr.im;
        w[SR_EXL]        = sr.exl;
        w[SR_IE]         = sr.ie;
        return w;
    endfunction

    function automatic logic [31:0] pack_cause(input cause_t c, input logic ti);
        logic [31:0] w;
        w = '0;
        w[CAUSE_BD]            = c.bd;
        w[CAUSE_TI]            = ti;
        w[CAUSE_IP_LO +: 6]    = c.ip;
        w[CAUSE_EXC_LO +: 5]   = c.exc_code;
        return w;
    endfunction

endpackage

// File: rtl/cp0_if.sv
// Pipeline <-> CP0 connection: mfc0/mtc0 access, M-stage exception info,
// interrupt lines, and the flush request / EPC returned to the pipeline.
interface cp0_if;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] pc_in;
    logic        bd_in;
    logic [4:0]  exc_in;
    logic [31:0] badvaddr_in;
    logic [5:0]  hw_int;
    logic        eret;
    logic        req;
    logic [31:0] epc_out;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, pc_in, bd_in, exc_in,
               badvaddr_in, hw_int, eret,
        input  rd_data, req, epc_out
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, pc_in, bd_in, exc_in,
               badvaddr_in, hw_int, eret,
        output rd_data, req, epc_out
    );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer. Count free-runs and wraps; TI is sticky until
// Compare is rewritten. An mtc0 that is squashed by an exception has no effect.
module cp0_timer
    import cp0_pkg::*;
#(
    parameter bit TIMER_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        suppress,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q, ti_d;
    logic        wr_ok;

    always_comb begin
        wr_ok     = wr_en & ~suppress;
        count_d   = count_q + 32'd1;
        compare_d = compare_q;
        ti_d      = ti_q;
        if (wr_ok && wr_addr == REG_COUNT)
            count_d = wr_data;
        if (!TIMER_EN)
            count_d = '0;
        if (wr_ok && wr_addr == REG_COMPARE)
            compare_d = wr_data;
        if (TIMER_EN && count_d == compare_q)
            ti_d = 1'b1;
        // A Compare write clears TI even if the match fires on the same edge.
        if (wr_ok && wr_addr == REG_COMPARE)
            ti_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign ti      = ti_q;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0 for the M stage: merges exceptions, interrupts and the timer
// into the flush request, and holds SR/Cause/EPC/BadVAddr for mfc0/mtc0/eret.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID     = 32'h0000_4C01,
    parameter bit          TIMER_EN = 1'b1
) (
    input logic   clk,
    input logic   reset,
    cp0_if.slave  bus
);

    sr_t         sr_q, sr_d;
    cause_t      cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;

    logic [31:0] count, compare;
    logic        ti;
    logic [5:0]  ip_next;
    logic        int_req, exc_req, req, wr_ok, addr_exc;
    logic [31:0] pc_aligned;
    logic        unused_pc_low;

    assign unused_pc_low = ^bus.pc_in[1:0];

    cp0_timer #(.TIMER_EN(TIMER_EN)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (bus.wr_en),
        .wr_addr  (bus.wr_addr),
        .wr_data  (bus.wr_data),
        .suppress (req),
        .count    (count),
        .compare  (compare),
        .ti       (ti)
    );

    // Request combiner; interrupts win over a simultaneous synchronous exception.
    always_comb begin
        ip_next    = {bus.hw_int[5] | ti, bus.hw_int[4:0]};
        int_req    = (|(ip_next & sr_q.im)) & sr_q.ie & ~sr_q.exl;
        exc_req    = (bus.exc_in != 5'd0) & ~sr_q.exl;
        req        = int_req | exc_req;
        wr_ok      = bus.wr_en & ~req;
        addr_exc   = (bus.exc_in == EXC_ADEL) || (bus.exc_in == EXC_ADES);
        pc_aligned = {bus.pc_in[31:2], 2'b00};
    end

    always_comb begin
        sr_d       = sr_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        cause_d.ip = ip_next;
        if (req) begin
            sr_d.exl         = 1'b1;
            cause_d.bd       = bus.bd_in;
            cause_d.exc_code = int_req ? EXC_INT : bus.exc_in;
            epc_d            = bus.bd_in ? pc_aligned - 32'd4 : pc_aligned;
            if (!int_req && addr_exc)
                badvaddr_d = bus.badvaddr_in;
        end else begin
            if (wr_ok && bus.wr_addr == REG_SR) begin
                sr_d.im  = bus.wr_data[SR_IM_LO +: 6];
                sr_d.exl = bus.wr_data[SR_EXL];
                sr_d.ie  = bus.wr_data[SR_IE];
            end else if (bus.eret) begin
                sr_d.exl = 1'b0;
            end
            if (wr_ok && bus.wr_addr == REG_EPC)
                epc_d = bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q       <= '0;
            cause_q    <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            sr_q       <= sr_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    // Reads see pre-edge register values; there is no bypass from mtc0.
    always_comb begin
        case (bus.rd_addr)
            REG_BADVADDR: bus.rd_data = badvaddr_q;
            REG_COUNT:    bus.rd_data = count;
            REG_COMPARE:  bus.rd_data = compare;
            REG_SR:       bus.rd_data = pack_sr(sr_q);
            REG_CAUSE:    bus.rd_data = pack_cause(cause_q, ti);
            REG_EPC:      bus.rd_data = epc_q;
            REG_PRID:     bus.rd_data = PRID;
            default:      bus.rd_data = '0;
        endcase
    end

    assign bus.req     = req;
    assign bus.epc_out = epc_q;

endmodule
